// File: rtl/mem_arb_pkg.sv
// Shared encodings and constants for the two-lane data-memory port arbiter.
// Lane index 0 is the older pipeline lane (lane 1), index 1 the younger (lane 2).
package mem_arb_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACC1 = 2'd1;
  localparam logic [1:0] ST_ACC2 = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam int          TIMEOUT_DEFAULT = 255;
  localparam logic [31:0] ERR_WORD        = 32'hDEADBEEF;
  localparam int          NUM_LANES       = 2;

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
  } lane_req_t;

  // A lane asking for both a read and a write is demoted to a plain write,
  // so a latched request can never carry both commands.
  function automatic lane_req_t make_req(
    input logic        rd,
    input logic        wr,
    input logic [31:0] addr,
    input logic [31:0] wdata
  );
    lane_req_t r;
    r.rd    = rd & ~wr;
    r.wr    = wr;
    r.addr  = addr;
    r.wdata = wdata;
    return r;
  endfunction

  function automatic logic req_valid(input logic rd, input logic wr);
    return rd | wr;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Pipeline-side and data-memory-side signals of the arbiter, bundled together.
// The arbiter uses the slave view; the pipeline/memory environment uses master.
interface mem_port_arbiter_if;

  logic        MemRead1;
  logic        MemWrite1;
  logic        MemRead2;
  logic        MemWrite2;
  logic [31:0] aluResult1;
  logic [31:0] aluResult2;
  logic [31:0] writeData1;
  logic [31:0] writeData2;
  logic [31:0] data_read_fDM;
  logic        dm_ready;

  logic        MemRead_2DM;
  logic        MemWrite_2DM;
  logic [31:0] data_address_2DM;
  logic [31:0] data_write_2DM;
  logic        stall_MEM;
  logic [31:0] data_read1;
  logic [31:0] data_read2;
  logic        bundle_done;
  logic        mem_err;

  modport slave (
    input  MemRead1,
    input  MemWrite1,
    input  MemRead2,
    input  MemWrite2,
    input  aluResult1,
    input  aluResult2,
    input  writeData1,
    input  writeData2,
    input  data_read_fDM,
    input  dm_ready,
    output MemRead_2DM,
    output MemWrite_2DM,
    output data_address_2DM,
    output data_write_2DM,
    output stall_MEM,
    output data_read1,
    output data_read2,
    output bundle_done,
    output mem_err
  );

  modport master (
    output MemRead1,
    output MemWrite1,
    output MemRead2,
    output MemWrite2,
    output aluResult1,
    output aluResult2,
    output writeData1,
    output writeData2,
    output data_read_fDM,
    output dm_ready,
    input  MemRead_2DM,
    input  MemWrite_2DM,
    input  data_address_2DM,
    input  data_write_2DM,
    input  stall_MEM,
    input  data_read1,
    input  data_read2,
    input  bundle_done,
    input  mem_err
  );

endinterface

// File: rtl/mem_arb_watchdog.sv
// Counts cycles spent in one access state and flags the cycle on which the
// access has used up its TIMEOUT budget without a completion strobe.
module mem_arb_watchdog #(
  parameter int TIMEOUT = mem_arb_pkg::TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic ready,
  output logic expired
);

  // The counter holds (cycles already spent - 1), so the TIMEOUT-th cycle
  // is the last one the access is allowed to occupy.
  localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  assign expired = active & ~ready & (cnt_q == LIMIT);

  // Any completion (real or forced) changes state, so clearing here is the
  // same as clearing on every state entry.
  always_comb begin
    cnt_d = cnt_q + 8'd1;
    if (!active || ready || expired) begin
      cnt_d = 8'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises the two pipeline lanes' memory requests onto one data-memory
// port, lane 1 first, stalling the MEM stage until the whole bundle is done.
module mem_port_arbiter #(
  parameter int TIMEOUT = mem_arb_pkg::TIMEOUT_DEFAULT
) (
  input logic               CLK,
  input logic               RESET,
  mem_port_arbiter_if.slave bus
);

  import mem_arb_pkg::*;

  logic [1:0]  state_q;
  logic [1:0]  state_d;
  logic        err_q;
  logic        err_d;

  logic        any_req;
  logic        conflict;
  logic        latch;
  logic        in_acc;
  logic        wd_expired;
  logic        advance;

  lane_req_t   lane_in    [NUM_LANES];
  lane_req_t   lane_cmd   [NUM_LANES];
  logic [31:0] lane_rdata [NUM_LANES];
  lane_req_t   cur;

  assign lane_in[0] = make_req(bus.MemRead1, bus.MemWrite1, bus.aluResult1, bus.writeData1);
  assign lane_in[1] = make_req(bus.MemRead2, bus.MemWrite2, bus.aluResult2, bus.writeData2);

  assign any_req  = bus.MemRead1 | bus.MemWrite1 | bus.MemRead2 | bus.MemWrite2;
  assign conflict = (bus.MemRead1 & bus.MemWrite1) | (bus.MemRead2 & bus.MemWrite2);
  assign in_acc   = (state_q == ST_ACC1) | (state_q == ST_ACC2);
  assign latch    = (state_q == ST_IDLE) & any_req;
  assign advance  = in_acc & (bus.dm_ready | wd_expired);

  mem_arb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (CLK),
    .rst     (RESET),
    .active  (in_acc),
    .ready   (bus.dm_ready),
    .expired (wd_expired)
  );

  generate
    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      localparam logic [1:0] LANE_ST = (gi == 0) ? ST_ACC1 : ST_ACC2;

      lane_req_t   req_q;
      lane_req_t   req_d;
      logic [31:0] rdata_q;
      logic [31:0] rdata_d;

      // A forced completion (watchdog) returns the error word instead of
      // whatever happens to be on the memory read bus.
      always_comb begin
        req_d   = req_q;
        rdata_d = rdata_q;
        if (latch) begin
          req_d = lane_in[gi];
        end
        if (advance && (state_q == LANE_ST) && req_q.rd) begin
          rdata_d = bus.dm_ready ? bus.data_read_fDM : ERR_WORD;
        end
      end

      always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
          req_q   <= '0;
          rdata_q <= 32'd0;
        end else begin
          req_q   <= req_d;
          rdata_q <= rdata_d;
        end
      end

      assign lane_cmd[gi]   = req_q;
      assign lane_rdata[gi] = rdata_q;
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          state_d = req_valid(lane_in[0].rd, lane_in[0].wr) ? ST_ACC1 : ST_ACC2;
        end
      end
      ST_ACC1: begin
        if (advance) begin
          state_d = req_valid(lane_cmd[1].rd, lane_cmd[1].wr) ? ST_ACC2 : ST_DONE;
        end
      end
      ST_ACC2: begin
        if (advance) begin
          state_d = ST_DONE;
        end
      end
      default: begin
        // DONE: requests still asserted belong to the finished bundle.
        state_d = ST_IDLE;
      end
    endcase
    if ((latch && conflict) || (in_acc && wd_expired)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    cur = '0;
    if (state_q == ST_ACC1) begin
      cur = lane_cmd[0];
    end else if (state_q == ST_ACC2) begin
      cur = lane_cmd[1];
    end
  end

  assign bus.MemRead_2DM      = cur.rd & ~cur.wr;
  assign bus.MemWrite_2DM     = cur.wr;
  assign bus.data_address_2DM = cur.addr;
  assign bus.data_write_2DM   = cur.wdata;
  // Reset gates the only path from raw request inputs to an output.
  assign bus.stall_MEM        = ~RESET & (latch | in_acc);
  assign bus.bundle_done      = (state_q == ST_DONE);
  assign bus.data_read1       = lane_rdata[0];
  assign bus.data_read2       = lane_rdata[1];
  assign bus.mem_err          = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a small word memory answers the shared
// port, and each step compares outputs against hand-derived values.
module tb_mem_port_arbiter;

  logic CLK = 1'b0;
  logic RESET;
  int   passed = 0;
  int   failed = 0;
  int   total  = 0;
  int   n;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(
    .TIMEOUT (255)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  // Unwritten words read back as 0x1000_0000 | address.
  logic [31:0] wmem    [256];
  bit          written [256];

  always @(posedge CLK) begin
    if (bus.MemWrite_2DM && bus.dm_ready) begin
      wmem[bus.data_address_2DM[9:2]]    <= bus.data_write_2DM;
      written[bus.data_address_2DM[9:2]] <= 1'b1;
    end
  end

  always_comb begin
    if (written[bus.data_address_2DM[9:2]]) begin
      bus.data_read_fDM = wmem[bus.data_address_2DM[9:2]];
    end else begin
      bus.data_read_fDM = 32'h1000_0000 | bus.data_address_2DM;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
    #1;
  endtask

  task automatic set_req(input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1,
                         input logic r2, input logic w2, input logic [31:0] a2, input logic [31:0] d2);
    bus.MemRead1   = r1;
    bus.MemWrite1  = w1;
    bus.aluResult1 = a1;
    bus.writeData1 = d1;
    bus.MemRead2   = r2;
    bus.MemWrite2  = w2;
    bus.aluResult2 = a2;
    bus.writeData2 = d2;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit exceeded");
  end

  initial begin
    RESET        = 1'b1;
    bus.dm_ready = 1'b0;
    set_req(1'b1, 1'b0, 32'h100, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(negedge CLK);
    #1;
    // Reset state, with a request already pending on lane 1.
    check("rst_stall", bus.stall_MEM, 1'b0);
    check("rst_rd_cmd", bus.MemRead_2DM, 1'b0);
    check("rst_addr", bus.data_address_2DM, 32'h0);
    check("rst_data_read1", bus.data_read1, 32'h0);
    check("rst_mem_err", bus.mem_err, 1'b0);
    check("rst_bundle_done", bus.bundle_done, 1'b0);
    set_req(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    RESET = 1'b0;
    tick();

    // Lane-1 read of 0x100 with dm_ready already high.
    bus.dm_ready = 1'b1;
    set_req(1'b1, 1'b0, 32'h100, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    check("t1_idle_stall", bus.stall_MEM, 1'b1);
    check("t1_idle_cmd", bus.MemRead_2DM, 1'b0);
    tick();
    check("t1_acc_rd", bus.MemRead_2DM, 1'b1);
    check("t1_acc_wr", bus.MemWrite_2DM, 1'b0);
    check("t1_acc_addr", bus.data_address_2DM, 32'h100);
    check("t1_acc_stall", bus.stall_MEM, 1'b1);
    check("t1_acc_done", bus.bundle_done, 1'b0);
    tick();
    check("t1_done_pulse", bus.bundle_done, 1'b1);
    check("t1_done_stall", bus.stall_MEM, 1'b0);
    check("t1_done_data", bus.data_read1, 32'h1000_0100);
    check("t1_done_cmd", bus.MemRead_2DM, 1'b0);
    set_req(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    check("t1_idle_done", bus.bundle_done, 1'b0);
    check("t1_idle_hold", bus.data_read1, 32'h1000_0100);

    // Lane-1 store then lane-2 load of the same address in one bundle.
    set_req(1'b0, 1'b1, 32'h40, 32'hCAFE_F00D, 1'b1, 1'b0, 32'h40, 32'h1234_5678);
    #1;
    check("t2_idle_stall", bus.stall_MEM, 1'b1);
    tick();
    check("t2_acc1_wr", bus.MemWrite_2DM, 1'b1);
    check("t2_acc1_rd", bus.MemRead_2DM, 1'b0);
    check("t2_acc1_addr", bus.data_address_2DM, 32'h40);
    check("t2_acc1_wdata", bus.data_write_2DM, 32'hCAFE_F00D);
    tick();
    check("t2_acc2_rd", bus.MemRead_2DM, 1'b1);
    check("t2_acc2_wr", bus.MemWrite_2DM, 1'b0);
    check("t2_acc2_addr", bus.data_address_2DM, 32'h40);
    check("t2_acc2_wdata", bus.data_write_2DM, 32'h1234_5678);
    check("t2_acc2_stall", bus.stall_MEM, 1'b1);
    tick();
    check("t2_done_pulse", bus.bundle_done, 1'b1);
    check("t2_done_data2", bus.data_read2, 32'hCAFE_F00D);
    check("t2_done_data1", bus.data_read1, 32'h1000_0100);
    check("t2_done_err", bus.mem_err, 1'b0);
    set_req(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();

    // Lane-2 read only, memory slow by five cycles.
    bus.dm_ready = 1'b0;
    set_req(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h200, 32'h0);
    #1;
    check("t3_idle_stall", bus.stall_MEM, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("t3_wait%0d_rd", i), bus.MemRead_2DM, 1'b1);
      check($sformatf("t3_wait%0d_addr", i), bus.data_address_2DM, 32'h200);
      check($sformatf("t3_wait%0d_stall", i), bus.stall_MEM, 1'b1);
    end
    tick();
    bus.dm_ready = 1'b1;
    #1;
    check("t3_ready_addr", bus.data_address_2DM, 32'h200);
    check("t3_ready_done", bus.bundle_done, 1'b0);
    tick();
    check("t3_done_pulse", bus.bundle_done, 1'b1);
    check("t3_done_data2", bus.data_read2, 32'h1000_0200);
    set_req(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();

    // Lane 1 asks for read and write at once.
    set_req(1'b1, 1'b1, 32'h80, 32'hA5A5_A5A5, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    check("t6_idle_err", bus.mem_err, 1'b0);
    tick();
    check("t6_acc_wr", bus.MemWrite_2DM, 1'b1);
    check("t6_acc_rd", bus.MemRead_2DM, 1'b0);
    check("t6_acc_addr", bus.data_address_2DM, 32'h80);
    check("t6_acc_err", bus.mem_err, 1'b1);
    tick();
    check("t6_done_pulse", bus.bundle_done, 1'b1);
    check("t6_done_data1", bus.data_read1, 32'h1000_0100);
    set_req(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    check("t6_err_sticky", bus.mem_err, 1'b1);

    // Reset pulsed in the middle of a lane-2 access.
    bus.dm_ready = 1'b0;
    set_req(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h300, 32'h0);
    tick();
    check("t5_acc2_rd", bus.MemRead_2DM, 1'b1);
    check("t5_acc2_addr", bus.data_address_2DM, 32'h300);
    tick();
    RESET = 1'b1;
    #1;
    check("t5_rst_rd", bus.MemRead_2DM, 1'b0);
    check("t5_rst_addr", bus.data_address_2DM, 32'h0);
    check("t5_rst_stall", bus.stall_MEM, 1'b0);
    check("t5_rst_data1", bus.data_read1, 32'h0);
    check("t5_rst_data2", bus.data_read2, 32'h0);
    check("t5_rst_err", bus.mem_err, 1'b0);
    set_req(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    RESET = 1'b0;
    tick();
    check("t5_post_rd", bus.MemRead_2DM, 1'b0);
    check("t5_post_stall", bus.stall_MEM, 1'b0);
    tick();
    check("t5_post2_rd", bus.MemRead_2DM, 1'b0);
    check("t5_post2_done", bus.bundle_done, 1'b0);

    // Memory never answers: the access is aborted after 255 cycles.
    set_req(1'b1, 1'b0, 32'h500, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    check("t4_first_err", bus.mem_err, 1'b0);
    n = 0;
    while (bus.MemRead_2DM === 1'b1 && n < 300) begin
      n++;
      tick();
    end
    check("t4_acc_cycles", 32'(n), 32'd255);
    check("t4_done_pulse", bus.bundle_done, 1'b1);
    check("t4_done_data1", bus.data_read1, 32'hDEAD_BEEF);
    check("t4_done_err", bus.mem_err, 1'b1);
    check("t4_done_stall", bus.stall_MEM, 1'b0);
    set_req(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    check("t4_idle_done", bus.bundle_done, 1'b0);
    check("t4_idle_err", bus.mem_err, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
